controlador_vga: RTL and testbench
==================================

CONTROLADOR_VGA -- requirements
Module: controlador_vga

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FRENTE / H_SINC / H_POSTERIOR, defaults 16 / 96 / 48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameter V_FRENTE / V_SINC / V_POSTERIOR, defaults 10 / 2 / 33, meaning vertical porch and sync widths in lines.
REQ-005 SHALL have port reloj  input  1  the 50 MHz system clock; the design SHALL use one clock, with all flops on its rising edge.
REQ-006 SHALL have port reset  input  1  the reset, which is synchronous and active-high.
REQ-007 SHALL have port habilitar  input  1  run enable; when low, the timing engine holds in idle.
REQ-008 SHALL have port tick_pixel  output  1  a one-reloj-cycle pulse marking each 25 MHz pixel slot.
REQ-009 SHALL have ports hsync and vsync  output  1 each  the sync outputs, active-low.
REQ-010 SHALL have port video_on  output  1  high while the beam is in the visible region.
REQ-011 SHALL have ports x and y  output  10 each  the current pixel column and line.
REQ-012 SHALL have port inicio_cuadro  output  1  a one-tick_pixel-wide pulse at pixel (0,0) of each frame.

Function
REQ-013 SHALL derive tick_pixel from a 1-bit toggle register: it toggles every reloj cycle while habilitar=1, and tick_pixel=1 when the toggle equals 1.
REQ-014 SHALL advance the counters only on reloj cycles where tick_pixel=1; no derived or gated clocks.
REQ-015 SHALL count x from 0 to H_TOTAL-1, where H_TOTAL = sum of the horizontal parameters (800); on wrap, x returns to 0 and y increments.
REQ-016 SHALL count y from 0 to V_TOTAL-1 (525); when x and y wrap together, both return to 0.
REQ-017 SHALL run a horizontal FSM with states ACTIVO -> FRENTE -> SINC -> POSTERIOR -> ACTIVO.
REQ-018 SHALL make each horizontal transition on the tick at which x crosses the corresponding boundary: 640, 656, 752, 800->0.
REQ-019 SHALL run an identical vertical FSM on y with boundaries 480, 490, 492, 525->0; it steps only on the horizontal wrap tick.
REQ-020 SHALL drive hsync=0 exactly while the horizontal FSM is in SINC (x 656..751), and 1 otherwise.
REQ-021 SHALL drive vsync=0 exactly while the vertical FSM is in SINC (y 490..491), and 1 otherwise.
REQ-022 SHALL drive video_on=1 iff both FSMs are in ACTIVO and habilitar=1.
REQ-023 SHALL drive x, y, hsync, vsync and video_on directly from registers, with zero combinational delay relative to counter state.
REQ-024 SHALL assert inicio_cuadro while x=0, y=0 and habilitar=1.
REQ-025 SHALL, when habilitar falls mid-frame, synchronously return the toggle, counters and FSMs to their reset state on the next edge; the restart begins at (0,0).
REQ-026 SHALL, when habilitar rises, produce the first tick_pixel on the second reloj edge after the rise.
REQ-027 SHALL give reset priority over habilitar when both are asserted in the same cycle.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, set toggle=0, x=0 and y=0, and put both FSMs in ACTIVO.
REQ-029 SHALL hold these output values during and immediately after reset: tick_pixel=0, hsync=1, vsync=1, video_on=0, inicio_cuadro=0.
REQ-030 SHALL, when reset is asserted mid-frame, abort the frame on the next edge with no partial sync pulse extension.

Structure
REQ-031 SHALL place the default timing constants, the derived H_TOTAL/V_TOTAL, and the typedef enum for the four-state FSM in shared package vga_pkg.
REQ-032 SHALL implement each axis as one instance of sub-module generador_sinc, a parameterized counter+FSM with step/wrap ports; there SHALL be two instances.

Verification
REQ-033 SHALL cover: reset, then habilitar=1 -> tick_pixel on the 2nd edge, then every 2 cycles; x=1 after 2 ticks.
REQ-034 SHALL cover: run one line -> hsync low for exactly 96 ticks starting at x=656, and 800 ticks (1600 reloj cycles) per line.
REQ-035 SHALL cover: run one frame -> vsync low for 2 lines starting at y=490, 525 lines per frame, and one inicio_cuadro per 420000 ticks.
REQ-036 SHALL cover: video_on count per frame = 640*480 = 307200 ticks, and zero at x=640 and at y=480.
REQ-037 SHALL cover: reset asserted at x=700, y=491 -> next edge x=0, y=0, hsync=1, vsync=1; with habilitar=1 and reset=1 together, reset wins.
REQ-038 SHALL cover: habilitar dropped at x=300 -> next edge counters=0, video_on=0; re-enable restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg: default VGA 640x480 timing constants and the axis phase type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int H_VISIBLE_DEF   = 640;
  localparam int H_FRENTE_DEF    = 16;
  localparam int H_SINC_DEF      = 96;
  localparam int H_POSTERIOR_DEF = 48;

  localparam int V_VISIBLE_DEF   = 480;
  localparam int V_FRENTE_DEF    = 10;
  localparam int V_SINC_DEF      = 2;
  localparam int V_POSTERIOR_DEF = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRENTE_DEF + H_SINC_DEF + H_POSTERIOR_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRENTE_DEF + V_SINC_DEF + V_POSTERIOR_DEF;

  localparam int ANCHO_CONT = 10;

  typedef enum logic [1:0] {
    F_ACTIVO    = 2'd0,
    F_FRENTE    = 2'd1,
    F_SINC      = 2'd2,
    F_POSTERIOR = 2'd3
  } fase_e;

endpackage

`default_nettype wire

// File: rtl/generador_sinc.sv
// ----------------------------------------------------------------------------
// generador_sinc: one VGA axis -- position counter plus porch/sync phase FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module generador_sinc
  import vga_pkg::*;
#(
  parameter int ANCHO_VISIBLE   = 640,
  parameter int ANCHO_FRENTE    = 16,
  parameter int ANCHO_SINC      = 96,
  parameter int ANCHO_POSTERIOR = 48,
  parameter int W               = 10
) (
  input  logic         reloj_i,
  input  logic         reset_i,
  input  logic         limpiar_i,
  input  logic         paso_i,
  output logic [W-1:0] cuenta_o,
  output logic         vuelta_o,
  output logic         sinc_n_o,
  output logic         activo_o
);

  localparam int TOTAL = ANCHO_VISIBLE + ANCHO_FRENTE + ANCHO_SINC + ANCHO_POSTERIOR;

  localparam logic [W-1:0] FIN_ACTIVO = W'(ANCHO_VISIBLE);
  localparam logic [W-1:0] FIN_FRENTE = W'(ANCHO_VISIBLE + ANCHO_FRENTE);
  localparam logic [W-1:0] FIN_SINC   = W'(ANCHO_VISIBLE + ANCHO_FRENTE + ANCHO_SINC);
  localparam logic [W-1:0] ULTIMO     = W'(TOTAL - 1);

  fase_e          fase_q, fase_d;
  logic [W-1:0]   cuenta_q, cuenta_d;
  logic           sinc_n_q, sinc_n_d;
  logic           activo_q, activo_d;
  logic           w_vuelta;

  assign w_vuelta = paso_i && (cuenta_q == ULTIMO);

  // Phase decisions look at the post-step count so outputs never lag the counter.
  always_comb begin
    cuenta_d = cuenta_q;
    fase_d   = fase_q;
    if (limpiar_i) begin
      cuenta_d = '0;
      fase_d   = F_ACTIVO;
    end else if (paso_i) begin
      cuenta_d = w_vuelta ? '0 : cuenta_q + W'(1);
      case (fase_q)
        F_ACTIVO:    if (cuenta_d == FIN_ACTIVO) fase_d = F_FRENTE;
        F_FRENTE:    if (cuenta_d == FIN_FRENTE) fase_d = F_SINC;
        F_SINC:      if (cuenta_d == FIN_SINC)   fase_d = F_POSTERIOR;
        F_POSTERIOR: if (w_vuelta)               fase_d = F_ACTIVO;
        default:                                 fase_d = F_ACTIVO;
      endcase
    end
    sinc_n_d = (fase_d != F_SINC);
    activo_d = (fase_d == F_ACTIVO);
  end

  always_ff @(posedge reloj_i) begin
    if (reset_i) begin
      cuenta_q <= '0;
      fase_q   <= F_ACTIVO;
      sinc_n_q <= 1'b1;
      activo_q <= 1'b1;
    end else begin
      cuenta_q <= cuenta_d;
      fase_q   <= fase_d;
      sinc_n_q <= sinc_n_d;
      activo_q <= activo_d;
    end
  end

  assign cuenta_o = cuenta_q;
  assign vuelta_o = w_vuelta;
  assign sinc_n_o = sinc_n_q;
  assign activo_o = activo_q;

endmodule

`default_nettype wire

// File: rtl/controlador_vga.sv
// ----------------------------------------------------------------------------
// controlador_vga: VGA timing engine, 25 MHz pixel slots from a 50 MHz clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module controlador_vga
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRENTE    = H_FRENTE_DEF,
  parameter int H_SINC      = H_SINC_DEF,
  parameter int H_POSTERIOR = H_POSTERIOR_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRENTE    = V_FRENTE_DEF,
  parameter int V_SINC      = V_SINC_DEF,
  parameter int V_POSTERIOR = V_POSTERIOR_DEF
) (
  input  logic                  reloj,
  input  logic                  reset,
  input  logic                  habilitar,
  output logic                  tick_pixel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_on,
  output logic [ANCHO_CONT-1:0] x,
  output logic [ANCHO_CONT-1:0] y,
  output logic                  inicio_cuadro
);

  logic toggle_q, toggle_d;
  logic w_limpiar;
  logic w_vuelta_h;
  logic w_vuelta_v_unused;
  logic w_h_activo, w_v_activo;

  // Dropping habilitar parks everything at (0,0) so a restart is frame-aligned.
  assign w_limpiar = ~habilitar;

  always_comb begin
    toggle_d = 1'b0;
    if (habilitar) toggle_d = ~toggle_q;
  end

  always_ff @(posedge reloj) begin
    if (reset) toggle_q <= 1'b0;
    else       toggle_q <= toggle_d;
  end

  generador_sinc #(
    .ANCHO_VISIBLE   (H_VISIBLE),
    .ANCHO_FRENTE    (H_FRENTE),
    .ANCHO_SINC      (H_SINC),
    .ANCHO_POSTERIOR (H_POSTERIOR),
    .W               (ANCHO_CONT)
  ) u_horizontal (
    .reloj_i   (reloj),
    .reset_i   (reset),
    .limpiar_i (w_limpiar),
    .paso_i    (toggle_q),
    .cuenta_o  (x),
    .vuelta_o  (w_vuelta_h),
    .sinc_n_o  (hsync),
    .activo_o  (w_h_activo)
  );

  generador_sinc #(
    .ANCHO_VISIBLE   (V_VISIBLE),
    .ANCHO_FRENTE    (V_FRENTE),
    .ANCHO_SINC      (V_SINC),
    .ANCHO_POSTERIOR (V_POSTERIOR),
    .W               (ANCHO_CONT)
  ) u_vertical (
    .reloj_i   (reloj),
    .reset_i   (reset),
    .limpiar_i (w_limpiar),
    .paso_i    (w_vuelta_h),
    .cuenta_o  (y),
    .vuelta_o  (w_vuelta_v_unused),
    .sinc_n_o  (vsync),
    .activo_o  (w_v_activo)
  );

  assign tick_pixel    = toggle_q;
  assign video_on      = w_h_activo & w_v_activo & habilitar & ~reset;
  assign inicio_cuadro = (x == '0) && (y == '0) && habilitar && !reset;

endmodule

`default_nettype wire

// File: tb/tb_controlador_vga.sv
// ----------------------------------------------------------------------------
// tb_controlador_vga: scoreboard bench with a linear pixel-index reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_controlador_vga;

  localparam int HV = 20, HF = 3, HS = 5, HP = 4;
  localparam int VV = 12, VF = 2, VS = 2, VP = 3;
  localparam int HT = HV + HF + HS + HP;
  localparam int VT = VV + VF + VS + VP;
  localparam int FR = HT * VT;

  logic       reloj = 1'b0;
  logic       reset = 1'b1;
  logic       habilitar = 1'b0;
  logic       tick_pixel, hsync, vsync, video_on, inicio_cuadro;
  logic [9:0] x, y;

  controlador_vga #(
    .H_VISIBLE(HV), .H_FRENTE(HF), .H_SINC(HS), .H_POSTERIOR(HP),
    .V_VISIBLE(VV), .V_FRENTE(VF), .V_SINC(VS), .V_POSTERIOR(VP)
  ) dut (
    .reloj         (reloj),
    .reset         (reset),
    .habilitar     (habilitar),
    .tick_pixel    (tick_pixel),
    .hsync         (hsync),
    .vsync         (vsync),
    .video_on      (video_on),
    .x             (x),
    .y             (y),
    .inicio_cuadro (inicio_cuadro)
  );

  always #5 reloj = ~reloj;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ini;
    logic [9:0] px;
    logic [9:0] py;
  } obs_t;

  obs_t cola[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: pixel slot phase and linear pixel index within the frame.
  bit m_t  = 1'b0;
  int m_px = 0;

  int medir    = 0;
  int von_cnt  = 0;
  int hs_cnt   = 0;
  int vs_cnt   = 0;
  int ini_cnt  = 0;
  int tick_cnt = 0;
  int hs_x0    = -1;
  int vs_y0    = -1;

  function automatic obs_t esperado(input bit rst, input bit hab);
    obs_t e;
    int   mx;
    int   my;
    mx    = m_px % HT;
    my    = m_px / HT;
    e.tick = m_t;
    e.hs   = !(mx >= HV + HF && mx < HV + HF + HS);
    e.vs   = !(my >= VV + VF && my < VV + VF + VS);
    e.von  = (mx < HV) && (my < VV) && hab && !rst;
    e.ini  = (m_px == 0) && hab && !rst;
    e.px   = 10'(mx);
    e.py   = 10'(my);
    return e;
  endfunction

  task automatic ciclo(input bit rst, input bit hab);
    @(posedge reloj);
    if (reset || !habilitar) begin
      m_t  = 1'b0;
      m_px = 0;
    end else begin
      if (m_t) m_px = (m_px + 1) % FR;
      m_t = !m_t;
    end
    #1;
    reset     = rst;
    habilitar = hab;
    cola.push_back(esperado(rst, hab));
  endtask

  task automatic avanzar_hasta(input int objetivo, input string nombre);
    int n;
    n = 0;
    while (m_px != objetivo && n < 2 * FR + 8) begin
      ciclo(1'b0, 1'b1);
      n++;
    end
    total++;
    if (m_px != objetivo) begin
      bad++;
      $display("FAIL %s timeout: reached pixel %0d, required %0d", nombre, m_px, objetivo);
    end
  endtask

  task automatic check(input string nombre, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nombre, got, exp);
    end
  endtask

  always @(negedge reloj) begin
    obs_t got;
    obs_t e;
    if (cola.size() > 0) begin
      e   = cola.pop_front();
      got = {tick_pixel, hsync, vsync, video_on, inicio_cuadro, x, y};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL salidas t=%0t got tick=%b hs=%b vs=%b von=%b ini=%b x=%0d y=%0d required tick=%b hs=%b vs=%b von=%b ini=%b x=%0d y=%0d",
                 $time, got.tick, got.hs, got.vs, got.von, got.ini, got.px, got.py,
                 e.tick, e.hs, e.vs, e.von, e.ini, e.px, e.py);
      end
      if (medir != 0) begin
        von_cnt  += int'(video_on);
        hs_cnt   += int'(!hsync);
        vs_cnt   += int'(!vsync);
        ini_cnt  += int'(inicio_cuadro);
        tick_cnt += int'(tick_pixel);
        if (!hsync && hs_x0 < 0) hs_x0 = int'(x);
        if (!vsync && vs_y0 < 0) vs_y0 = int'(y);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;

    // Reset alone, then reset together with habilitar: reset must win.
    repeat (3) ciclo(1'b1, 1'b0);
    repeat (3) ciclo(1'b1, 1'b1);
    repeat (2) ciclo(1'b0, 1'b0);

    // One clean frame from enable, measured sample by sample.
    ciclo(1'b0, 1'b1);
    medir = 1;
    repeat (2 * FR - 1) ciclo(1'b0, 1'b1);
    @(negedge reloj);
    #1 medir = 0;

    // Reset in the middle of both sync pulses.
    avanzar_hasta((VV + VF + 1) * HT + HV + HF + 2, "espera_sinc");
    ciclo(1'b1, 1'b1);
    repeat (2) ciclo(1'b0, 1'b0);
    repeat (6) ciclo(1'b0, 1'b1);

    // habilitar dropped mid-line, then re-enabled.
    avanzar_hasta(3 * HT + HV / 2, "espera_linea");
    repeat (2) ciclo(1'b0, 1'b0);
    repeat (2 * HT + 4) ciclo(1'b0, 1'b1);

    // Random reset/enable disturbances over several frames.
    repeat (3000) begin
      r = int'($urandom_range(0, 299));
      ciclo(r == 0, !(r >= 1 && r <= 3));
    end
    repeat (2) ciclo(1'b0, 1'b0);

    repeat (2) @(negedge reloj);
    #1;
    check("video_on_por_cuadro", von_cnt, 2 * HV * VV);
    check("hsync_bajo_por_cuadro", hs_cnt, 2 * HS * VT);
    check("vsync_bajo_por_cuadro", vs_cnt, 2 * VS * HT);
    check("inicio_cuadro_por_cuadro", ini_cnt, 2);
    check("ticks_por_cuadro", tick_cnt, FR);
    check("hsync_inicio_x", hs_x0, HV + HF);
    check("vsync_inicio_y", vs_y0, VV + VF);
    check("cola_vacia", cola.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
